// File: rtl/lcplc_stream_tagger.sv
// lcplc_stream_tagger: tags a raw sample stream with row/slice/block/image end flags
module lcplc_stream_tagger #(
    parameter int DATA_WIDTH      = 16,
    parameter int DIM_WIDTH       = 8,
    parameter int BLOCK_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIM_WIDTH-1:0]       cfg_cols,
    input  logic [DIM_WIDTH-1:0]       cfg_rows,
    input  logic [DIM_WIDTH-1:0]       cfg_bands,
    input  logic [BLOCK_CNT_WIDTH-1:0] cfg_blocks,
    input  logic                       x_valid,
    output logic                       x_ready,
    input  logic [DATA_WIDTH-1:0]      x_data,
    input  logic                       x_last,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [DATA_WIDTH-1:0]      y_data,
    output logic                       y_last_r,
    output logic                       y_last_s,
    output logic                       y_last_b,
    output logic                       y_last_i,
    output logic                       busy,
    output logic                       err_last
);
    localparam int BW = DATA_WIDTH + 4;
    localparam logic [DIM_WIDTH-1:0] D1 = DIM_WIDTH'(1);
    localparam logic [BLOCK_CNT_WIDTH-1:0] B1 = BLOCK_CNT_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                     state_q;
    logic [DIM_WIDTH-1:0]       cols_q, rows_q, bands_q, col_q, row_q, band_q;
    logic [DIM_WIDTH-1:0]       cols, rows, bands, col_d, row_d, band_d;
    logic [BLOCK_CNT_WIDTH-1:0] blocks_q, blk_q, blocks, blk_d;
    logic                       x_ready_q, y_valid_q, sk_valid_q, err_q;
    logic [BW-1:0]              out_q, sk_q, beat;
    logic                       accept, out_free, lr, ls, lb, li_c;

    // In IDLE the live config governs the first beat of an image; zero counts as one
    assign cols   = (state_q == IDLE) ? ((cfg_cols   == '0) ? D1 : cfg_cols)   : cols_q;
    assign rows   = (state_q == IDLE) ? ((cfg_rows   == '0) ? D1 : cfg_rows)   : rows_q;
    assign bands  = (state_q == IDLE) ? ((cfg_bands  == '0) ? D1 : cfg_bands)  : bands_q;
    assign blocks = (state_q == IDLE) ? ((cfg_blocks == '0) ? B1 : cfg_blocks) : blocks_q;

    assign accept   = x_valid & x_ready_q;
    assign out_free = ~y_valid_q | y_ready;

    // Flags come from the counters before they advance
    assign lr   = col_q == cols - D1;
    assign ls   = lr & (row_q == rows - D1);
    assign lb   = ls & (band_q == bands - D1);
    assign li_c = lb & (blk_q == blocks - B1);

    // Upstream x_last is authoritative: it forces every end flag so the stream resyncs
    assign beat = {x_last, lb | x_last, ls | x_last, lr | x_last, x_data};

    // Column-fastest nested counters, each wrap carrying into the next
    assign col_d  = lr ? '0 : col_q + D1;
    assign row_d  = lr ? (ls ? '0 : row_q + D1) : row_q;
    assign band_d = ls ? (lb ? '0 : band_q + D1) : band_q;
    assign blk_d  = lb ? (li_c ? '0 : blk_q + B1) : blk_q;

    // Image FSM, config latch and position counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cols_q   <= '0;
            rows_q   <= '0;
            bands_q  <= '0;
            blocks_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            band_q   <= '0;
            blk_q    <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            cols_q   <= cols;
            rows_q   <= rows;
            bands_q  <= bands;
            blocks_q <= blocks;
            err_q    <= err_q | (x_last != li_c);
            state_q  <= x_last ? IDLE : RUN;
            col_q    <= x_last ? '0 : col_d;
            row_q    <= x_last ? '0 : row_d;
            band_q   <= x_last ? '0 : band_d;
            blk_q    <= x_last ? '0 : blk_d;
        end
    end

    // Output register plus one skid entry; x_ready drops only while the skid is occupied
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_ready_q  <= 1'b0;
            y_valid_q  <= 1'b0;
            sk_valid_q <= 1'b0;
            out_q      <= '0;
            sk_q       <= '0;
        end else if (sk_valid_q) begin
            if (out_free) begin
                out_q      <= sk_q;
                sk_valid_q <= 1'b0;
                x_ready_q  <= 1'b1;
            end
        end else if (accept) begin
            if (out_free) begin
                out_q     <= beat;
                y_valid_q <= 1'b1;
            end else begin
                sk_q       <= beat;
                sk_valid_q <= 1'b1;
                x_ready_q  <= 1'b0;
            end
        end else begin
            if (y_ready) y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
        end
    end

    assign x_ready  = x_ready_q;
    assign y_valid  = y_valid_q;
    assign y_data   = out_q[DATA_WIDTH-1:0];
    assign y_last_r = out_q[DATA_WIDTH];
    assign y_last_s = out_q[DATA_WIDTH+1];
    assign y_last_b = out_q[DATA_WIDTH+2];
    assign y_last_i = out_q[DATA_WIDTH+3];
    assign busy     = (state_q == RUN) | sk_valid_q;
    assign err_last = err_q;
endmodule

// File: tb/tb_lcplc_stream_tagger.sv
// tb_lcplc_stream_tagger: scoreboard bench for the stream tagger
module tb_lcplc_stream_tagger;
    logic        clk = 0, rst = 0;
    logic [7:0]  cfg_cols, cfg_rows, cfg_bands;
    logic [15:0] cfg_blocks;
    logic        x_valid = 0, x_ready, x_last = 0;
    logic [15:0] x_data = 0, y_data;
    logic        y_valid, y_ready = 0;
    logic        y_last_r, y_last_s, y_last_b, y_last_i, busy, err_last;

    logic [19:0] sb[$];
    int          n_tests = 0, n_fail = 0, tcnt = 0, npop = 0, first_pop = -1, last_pop = 0;
    int          rmode = 0;
    bit          hold_pend = 0, chk_busy = 0;
    logic [20:0] hold_v;

    lcplc_stream_tagger dut (
        .clk(clk), .rst(rst),
        .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_bands(cfg_bands), .cfg_blocks(cfg_blocks),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .y_last_r(y_last_r), .y_last_s(y_last_s), .y_last_b(y_last_b), .y_last_i(y_last_i),
        .busy(busy), .err_last(err_last)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] expv(int k, int c, int r, int b, int bl, logic [15:0] d);
        int s  = c * r;
        int bb = s * b;
        logic lr = (k % c) == c - 1;
        logic ls = (k % s) == s - 1;
        logic lb = (k % bb) == bb - 1;
        logic li = k == bb * bl - 1;
        return {li, lb, ls, lr, d};
    endfunction

    function automatic logic ready_now();
        return (rmode == 0) || (tcnt % 3 == 0);
    endfunction

    task automatic monitor();
        logic [19:0] e;
        logic [19:0] cur = {y_last_i, y_last_b, y_last_s, y_last_r, y_data};
        if (hold_pend) chk("hold", {11'd0, y_valid, cur}, {11'd0, hold_v});
        hold_pend = y_valid && !y_ready;
        hold_v = {y_valid, cur};
        if (y_valid && y_ready) begin
            if (sb.size() == 0) chk("extra_beat", {12'd0, cur}, 32'hFFFFFFFF);
            else begin
                e = sb.pop_front();
                chk("beat", {12'd0, cur}, {12'd0, e});
                npop++;
                if (first_pop < 0) first_pop = tcnt;
                last_pop = tcnt;
            end
        end
        if (chk_busy) chk("busy", {31'd0, busy}, 0);
    endtask

    task automatic send(logic [15:0] d, bit xl, logic [19:0] e);
        int  n = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            tcnt++;
            x_valid = 1; x_data = d; x_last = xl; y_ready = ready_now();
            monitor();
            if (x_ready) begin
                sb.push_back(e);
                done = 1;
            end else if (++n > 100) begin
                chk("x_timeout", 1, 0);
                done = 1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || y_valid) && n < 300) begin
            @(negedge clk);
            tcnt++;
            x_valid = 0; x_last = 0; y_ready = ready_now();
            monitor();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic send_image(int c, int r, int b, int bl, int base);
        int t = c * r * b * bl;
        for (int k = 0; k < t; k++) send(16'(base + k), k == t - 1, expv(k, c, r, b, bl, 16'(base + k)));
    endtask

    task automatic set_cfg(int c, int r, int b, int bl);
        cfg_cols = 8'(c); cfg_rows = 8'(r); cfg_bands = 8'(b); cfg_blocks = 16'(bl);
    endtask

    initial begin
        set_cfg(4, 2, 3, 2);
        repeat (2) @(negedge clk);
        chk("rst_out", {y_valid, x_ready, busy, err_last, y_last_r, y_last_s, y_last_b, y_last_i}, 0);
        rst = 1;
        @(negedge clk);
        chk("x_ready_after_rst", {31'd0, x_ready}, 1);

        // Full image, continuous ready: no bubbles
        first_pop = -1; npop = 0;
        send_image(4, 2, 3, 2, 0);
        drain();
        chk("a_count", npop, 48);
        chk("a_bubbles", last_pop - first_pop, 47);
        chk("a_err", {31'd0, err_last}, 0);

        // Same image with 1-on/2-off backpressure
        rmode = 1; npop = 0;
        send_image(4, 2, 3, 2, 0);
        drain();
        rmode = 0;
        chk("b_count", npop, 48);
        chk("b_err", {31'd0, err_last}, 0);

        // All-zero config: every sample is a one-sample image
        set_cfg(0, 0, 0, 0);
        chk_busy = 1;
        for (int i = 0; i < 5; i++) send(16'(100 + i), 1, {4'hF, 16'(100 + i)});
        drain();
        chk_busy = 0;
        chk("c_err", {31'd0, err_last}, 0);

        // Early x_last on sample 10, then a clean image from sample 11
        set_cfg(4, 2, 3, 2);
        for (int i = 0; i < 11; i++) send(16'(i), i == 10, (i == 10) ? {4'hF, 16'(i)} : expv(i, 4, 2, 3, 2, 16'(i)));
        for (int k = 0; k < 48; k++) send(16'(11 + k), k == 47, expv(k, 4, 2, 3, 2, 16'(11 + k)));
        drain();
        chk("d_err", {31'd0, err_last}, 1);

        // Reset mid-image discards it; the next image starts from zero
        for (int i = 0; i < 20; i++) send(16'(200 + i), 0, expv(i, 4, 2, 3, 2, 16'(200 + i)));
        @(negedge clk);
        x_valid = 0;
        #2 rst = 0;
        #1;
        chk("e_rst_async", {y_valid, x_ready, busy, err_last, y_last_r, y_last_s, y_last_b, y_last_i}, 0);
        sb.delete();
        hold_pend = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("e_x_ready", {31'd0, x_ready}, 1);
        first_pop = -1; npop = 0;
        send_image(4, 2, 3, 2, 300);
        drain();
        chk("e_count", npop, 48);
        chk("e_bubbles", last_pop - first_pop, 47);
        chk("e_err", {31'd0, err_last}, 0);

        // cfg_cols change mid-image only takes effect on the next image
        npop = 0;
        for (int k = 0; k < 10; k++) send(16'(400 + k), 0, expv(k, 4, 2, 3, 2, 16'(400 + k)));
        cfg_cols = 8'd2;
        for (int k = 10; k < 48; k++) send(16'(400 + k), k == 47, expv(k, 4, 2, 3, 2, 16'(400 + k)));
        send_image(2, 2, 3, 2, 500);
        drain();
        chk("f_count", npop, 72);
        chk("f_err", {31'd0, err_last}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lcplc_stream_tagger.md
LCPLC_STREAM_TAGGER -- requirements
Module: lcplc_stream_tagger

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter DIM_WIDTH, default 8, width of every dimension config port and counter.
REQ-003 SHALL have parameter BLOCK_CNT_WIDTH, default 16, width of the block count config port and counter.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cfg_cols, cfg_rows, cfg_bands  input  DIM_WIDTH each  block columns, block rows, and bands, value n meaning n.
REQ-007 SHALL have port cfg_blocks  input  BLOCK_CNT_WIDTH  blocks per image, value n meaning n.
REQ-008 SHALL have ports x_valid, x_ready, x_data, x_last  in/out/in/in  1/1/DATA_WIDTH/1  raw AXIS input; x_last is the upstream image end marker.
REQ-009 SHALL have ports y_valid, y_ready, y_data  out/in/out  1/1/DATA_WIDTH  tagged AXIS output.
REQ-010 SHALL have ports y_last_r, y_last_s, y_last_b, y_last_i  output  1 each  row, slice, block and image end flags.
REQ-011 SHALL have ports busy, err_last  output  1 each  image in progress; sticky x_last mismatch.

Function
REQ-012 SHALL order samples column fastest, then row, then band, then block.
REQ-013 SHALL implement states IDLE and RUN, with IDLE as the reset state.
REQ-014 SHALL latch all cfg_* ports in IDLE on the first accepted input; cfg changes during RUN SHALL have no effect.
REQ-015 SHALL treat any cfg value of 0 as 1.
REQ-016 SHALL go from IDLE to RUN on an accepted sample unless that sample ends the image, and from RUN to IDLE on acceptance of the sample with last_i set.
REQ-017 SHALL hold counters col, row, band, blk, all zero on entry to IDLE.
REQ-018 SHALL increment col on each accepted input and wrap col at cols-1; each wrap SHALL carry into the next counter in the order col, row, band, blk.
REQ-019 SHALL set last_r when col equals cols-1.
REQ-020 SHALL set last_s when last_r is set and row equals rows-1.
REQ-021 SHALL set last_b when last_s is set and band equals bands-1.
REQ-022 SHALL set last_i when last_b is set and blk equals blocks-1.
REQ-023 SHALL compute the flags from counter values before the increment and register them alongside the data.
REQ-024 SHALL add exactly 1 cycle of latency from input handshake to y_valid.
REQ-025 SHALL sustain 1 sample per cycle when y_ready is held high.
REQ-026 SHALL drive x_ready from a register; a 2-entry skid buffer SHALL absorb one in-flight beat when y_ready drops.
REQ-027 SHALL keep y_data and flags stable while y_valid is high and y_ready is low.
REQ-028 SHALL never drop or duplicate a sample.
REQ-029 SHALL, on an accepted beat whose x_last differs from the computed last_i, set err_last (sticky) and output the beat with last_i equal to x_last.
REQ-030 SHALL, on an accepted beat with x_last=1, also set last_r, last_s and last_b and return the FSM to IDLE (resync).
REQ-031 SHALL drive busy high exactly while in RUN or while the skid buffer holds data.
REQ-032 SHALL tag a single-sample image (all cfg 1) with all four flags set and leave the FSM in IDLE.

Reset
REQ-033 SHALL, while rst is low, force y_valid=0, x_ready=0, busy=0, err_last=0, all flags 0, counters 0, skid buffer empty and state IDLE, asynchronously.
REQ-034 SHALL drive x_ready=1 on the first clk edge after rst deasserts.
REQ-035 SHALL discard any partial image when rst is asserted mid-image; the next image starts at counter zero.

Verification
REQ-036 SHALL verify: cols=4, rows=2, bands=3, blocks=2, 48 samples of value 0..47 with y_ready=1 -> last_r on 3,7,11,...; last_s on 7,15,23,...; last_b on 23 and 47; last_i only on 47; zero bubbles.
REQ-037 SHALL verify: same stream with y_ready toggling 1-cycle-on/2-cycles-off -> identical data and flag sequence, no loss, no duplication.
REQ-038 SHALL verify: cfg all 0 -> each sample carries all four flags; busy never high longer than 1 cycle per sample.
REQ-039 SHALL verify: cols=4, rows=2, bands=3, blocks=2 with x_last on sample 10 -> err_last=1, sample 10 has all flags set, sample 11 restarts at col 0 with last_r on sample 14.
REQ-040 SHALL verify: rst pulsed low after 20 samples of the first image -> outputs 0 during reset, then a full 48-sample image tags as in REQ-036.
REQ-041 SHALL verify: cfg_cols changed from 4 to 2 mid-image -> no effect until the next image; the next image uses 2.
